uart_tx_fifo_reader: RTL and testbench
======================================

Name: uart_tx_fifo_reader

Overview:
- Consumer end of the UART transmit FIFO. Pulls bytes through the FIFO's active-low read strobe and serialises each byte onto the TX line as a UART frame: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
- Sits between the 128-deep transmit FIFO and the TX pad, timed by the shared 16x baud enable.
- Prefetches the next byte during the stop bit so that back-to-back frames leave no idle gap.

Parameters:
- OVERSAMPLE, 16: BAUD_EN ticks per bit period (allowed range 2..16).
- READ_LAT, 2: clocks from the edge that samples FIFO_RDB low to FIFO_DATA valid (allowed range 1..3).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- BAUD_EN  in  1  one-cycle oversample tick, OVERSAMPLE ticks per bit.
- BIT8  in  1  1 = 8 data bits, 0 = 7 data bits.
- PARITY_EN  in  1  1 = append parity bit.
- ODD_N_EVEN  in  1  1 = odd parity, 0 = even parity.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_DATA  in  8  FIFO read data.
- FIFO_RDB  out  1  active-low read strobe, registered, one cycle per byte.
- TX  out  1  serial output, idle high, registered.
- TX_BUSY  out  1  high whenever state is not IDLE.
- TX_DONE  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (RESET low at a rising edge): TX=1, FIFO_RDB=1, TX_BUSY=0, TX_DONE=0, state=IDLE, bit counter=0, prefetch flag=0, shift and hold registers=0. Reset mid-frame aborts the frame; TX is high on the next edge and no further strobe is issued.
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE:
  - On FIFO_EMPTY=0, drive FIFO_RDB low for exactly one cycle (FETCH), then go to WAIT.
  - On FIFO_EMPTY=1, hold TX=1.
- WAIT:
  - Count READ_LAT cycles after the strobe edge, then capture FIFO_DATA into the shift register.
  - Latch BIT8, PARITY_EN and ODD_N_EVEN with the data.
  - Clear the oversample counter and go to START.
- Bit timing:
  - The oversample counter increments on BAUD_EN only.
  - A bit ends on the BAUD_EN where counter = OVERSAMPLE-1; the counter wraps to 0 there.
  - Each bit lasts exactly OVERSAMPLE BAUD_EN ticks.
- START: TX=0 for one bit.
- DATA:
  - Shift out LSB first, 8 bits if latched BIT8=1, else 7.
  - When 7 bits are selected, bit 7 is ignored.
- PARITY: entered only if latched PARITY_EN=1. TX = XOR of the transmitted data bits, inverted when ODD_N_EVEN=1.
- STOP:
  - TX=1 for one bit.
  - On STOP entry, if FIFO_EMPTY=0, issue one FIFO_RDB pulse and capture FIFO_DATA READ_LAT cycles later into the hold register; set the prefetch flag.
  - At the end of STOP, pulse TX_DONE.
  - If the prefetch flag is set: load the hold register and its config, clear the flag and the counter, and go to START. There is no idle cycle on TX.
  - Otherwise go to IDLE.
- FIFO_EMPTY is sampled only in IDLE and on STOP entry; it is never strobed when high.
- Config inputs changing mid-frame have no effect on that frame.
- BAUD_EN asserted during FETCH/WAIT is ignored, because the counter is cleared at load.
- Never more than one outstanding read; FIFO_RDB is never low for two consecutive cycles.

Test Plan:
- Reset check: RESET low 3 cycles with FIFO_EMPTY=0 -> TX=1, FIFO_RDB=1, TX_BUSY=0 throughout; single FIFO_RDB low pulse 1 cycle after reset release.
- 8N1 frame: byte 0x55, BIT8=1, PARITY_EN=0, BAUD_EN every cycle -> TX sequence 0,1,0,1,0,1,0,1,0,1, each level held 16 clocks; TX_DONE pulses once; TX_BUSY falls the next cycle.
- 7E1 frame: byte 0xC3, BIT8=0, PARITY_EN=1, ODD_N_EVEN=0 -> data bits 1,1,0,0,0,0,1, parity=1, stop=1; bit 7 never transmitted.
- Odd parity: byte 0x00, 8 bits, PARITY_EN=1, ODD_N_EVEN=1 -> parity bit=1.
- Back-to-back frames: FIFO holds 0xA5,0x3C -> second start bit begins the cycle after the first stop bit ends; exactly 2 FIFO_RDB pulses; 2 TX_DONE pulses; no idle-high gap between frames.
- Mid-frame reset: RESET asserted during data bit 3 -> TX=1 next edge, state IDLE, no FIFO_RDB while RESET low; a fresh frame starts after release if FIFO_EMPTY=0.

Source files
------------

// File: rtl/uart_tx_fifo_reader.sv
// UART transmit serialiser that drains the TX FIFO through an active-low read strobe.
// Frames are start + 7/8 data bits LSB first + optional parity + one stop bit; the next byte is prefetched during stop.
module uart_tx_fifo_reader #(
   parameter int OVERSAMPLE = 16,
   parameter int READ_LAT   = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       BAUD_EN,
   input  logic       BIT8,
   input  logic       PARITY_EN,
   input  logic       ODD_N_EVEN,
   input  logic       FIFO_EMPTY,
   input  logic [7:0] FIFO_DATA,
   output logic       FIFO_RDB,
   output logic       TX,
   output logic       TX_BUSY,
   output logic       TX_DONE
);

   localparam int              OS_W     = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [1:0]      LAT_LAST = 2'(READ_LAT);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   state_t          state, state_nxt;
   logic [OS_W-1:0] os_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            frame_bit8, frame_pe, frame_par;
   logic [7:0]      hold_data;
   logic            hold_bit8, hold_pe, hold_odd, prefetch;
   logic            rd_pend;
   logic [1:0]      rd_cnt;
   logic            tx_q, rdb_q, tx_nxt, rdb_nxt;

   logic       bit_end, rd_done, last_data, in_frame, stop_entry, start_read, load;
   logic [7:0] ld_data;
   logic       ld_bit8, ld_pe, ld_odd;

   assign bit_end    = BAUD_EN && (os_cnt == OS_LAST);
   assign rd_done    = rd_pend && (rd_cnt == LAT_LAST);
   assign last_data  = (bit_cnt == (frame_bit8 ? 3'd7 : 3'd6));
   assign in_frame   = (state == S_START) || (state == S_DATA) ||
                       (state == S_PARITY) || (state == S_STOP);
   assign stop_entry = (state != S_STOP) && (state_nxt == S_STOP);
   assign start_read = !FIFO_EMPTY && ((state == S_IDLE) || stop_entry);

   // A frame loads either straight from the FIFO bus (first byte, or a prefetch landing
   // exactly at stop end) or from the hold register filled during the previous stop bit.
   assign load    = ((state == S_WAIT) && rd_done) ||
                    ((state == S_STOP) && bit_end && (prefetch || rd_done));
   assign ld_data = rd_done ? FIFO_DATA  : hold_data;
   assign ld_bit8 = rd_done ? BIT8       : hold_bit8;
   assign ld_pe   = rd_done ? PARITY_EN  : hold_pe;
   assign ld_odd  = rd_done ? ODD_N_EVEN : hold_odd;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (!FIFO_EMPTY) state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_WAIT;
         S_WAIT:   if (rd_done) state_nxt = S_START;
         S_START:  if (bit_end) state_nxt = S_DATA;
         S_DATA:   if (bit_end && last_data) state_nxt = frame_pe ? S_PARITY : S_STOP;
         S_PARITY: if (bit_end) state_nxt = S_STOP;
         S_STOP: begin
            if (bit_end) begin
               if (prefetch || rd_done) state_nxt = S_START;
               else if (rd_pend)        state_nxt = S_WAIT;
               else                     state_nxt = S_IDLE;
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   // TX holds shift[0] throughout DATA, so a mid-data bit end presents shift[1].
   always_comb begin
      tx_nxt = 1'b1;
      unique case (state_nxt)
         S_START:  tx_nxt = 1'b0;
         S_DATA:   tx_nxt = ((state == S_DATA) && bit_end) ? shift[1] : shift[0];
         S_PARITY: tx_nxt = frame_par;
         default:  tx_nxt = 1'b1;
      endcase
      rdb_nxt = !start_read;
      TX_DONE = (state == S_STOP) && bit_end;
      TX_BUSY = (state != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state      <= S_IDLE;
         tx_q       <= 1'b1;
         rdb_q      <= 1'b1;
         os_cnt     <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         frame_bit8 <= 1'b0;
         frame_pe   <= 1'b0;
         frame_par  <= 1'b0;
         hold_data  <= '0;
         hold_bit8  <= 1'b0;
         hold_pe    <= 1'b0;
         hold_odd   <= 1'b0;
         prefetch   <= 1'b0;
         rd_pend    <= 1'b0;
         rd_cnt     <= '0;
      end else begin
         state <= state_nxt;
         tx_q  <= tx_nxt;
         rdb_q <= rdb_nxt;

         if (load)                    os_cnt <= '0;
         else if (in_frame && BAUD_EN) os_cnt <= bit_end ? '0 : os_cnt + 1'b1;

         if (load) begin
            bit_cnt    <= '0;
            shift      <= ld_data;
            frame_bit8 <= ld_bit8;
            frame_pe   <= ld_pe;
            frame_par  <= (^ld_data[6:0]) ^ (ld_bit8 & ld_data[7]) ^ ld_odd;
         end else if ((state == S_DATA) && bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {1'b0, shift[7:1]};
         end

         if (start_read) begin
            rd_pend <= 1'b1;
            rd_cnt  <= '0;
         end else if (rd_pend) begin
            if (rd_done) rd_pend <= 1'b0;
            else         rd_cnt  <= rd_cnt + 2'd1;
         end

         if (rd_done && !load) begin
            hold_data <= FIFO_DATA;
            hold_bit8 <= BIT8;
            hold_pe   <= PARITY_EN;
            hold_odd  <= ODD_N_EVEN;
            prefetch  <= 1'b1;
         end else if (load) begin
            prefetch  <= 1'b0;
         end
      end
   end

   assign TX       = tx_q;
   assign FIFO_RDB = rdb_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: a FIFO model with read latency feeds bytes, and each TX
// frame is compared bit by bit (level and BAUD_EN tick count) against a frame built from the byte.
module tb_uart_tx_fifo_reader;

   localparam int OVERSAMPLE = 16;
   localparam int READ_LAT   = 2;
   localparam int LIMIT      = 4000;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       BAUD_EN = 1'b0;
   logic       BIT8 = 1'b1;
   logic       PARITY_EN = 1'b0;
   logic       ODD_N_EVEN = 1'b0;
   logic       FIFO_EMPTY = 1'b1;
   logic [7:0] FIFO_DATA = 8'h00;
   logic       FIFO_RDB, TX, TX_BUSY, TX_DONE;

   int         errors = 0;
   int         checks = 0;
   int         rd_count = 0;
   bit         baud_fast = 1'b1;
   logic [7:0] fifo_q[$];

   uart_tx_fifo_reader #(.OVERSAMPLE(OVERSAMPLE), .READ_LAT(READ_LAT)) dut (
      .CLK(CLK), .RESET(RESET), .BAUD_EN(BAUD_EN), .BIT8(BIT8), .PARITY_EN(PARITY_EN),
      .ODD_N_EVEN(ODD_N_EVEN), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
      .FIFO_RDB(FIFO_RDB), .TX(TX), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE)
   );

   always #5 CLK = ~CLK;

   // Oversample tick: every cycle, or a random half of cycles.
   initial forever begin
      @(posedge CLK);
      #1 BAUD_EN = baud_fast ? 1'b1 : 1'($urandom_range(0, 1));
   end

   // FIFO: a strobe seen at an edge pops a byte that is valid on the bus only at the edge READ_LAT later.
   initial begin : fifo_model
      logic [7:0] pend;
      int         del;
      bit         low_now, low_prev;
      pend = 8'h00; del = -1; low_prev = 1'b0;
      forever begin
         @(negedge CLK);
         low_now = (FIFO_RDB === 1'b0);
         @(posedge CLK);
         #1;
         FIFO_DATA = 8'($urandom);
         if (del == 0) del = -1;
         else if (del > 0) begin
            del--;
            if (del == 0) FIFO_DATA = pend;
         end
         if (low_now) begin
            checks++;
            rd_count++;
            if (fifo_q.size() == 0 || low_prev) begin
               errors++;
               $display("FAIL rdb_strobe: empty=%0d back_to_back_low=%0d, required one strobe on a non-empty FIFO",
                        fifo_q.size() == 0, low_prev);
            end
            if (fifo_q.size() != 0) pend = fifo_q.pop_front();
            del = READ_LAT - 1;
            if (del == 0) FIFO_DATA = pend;
         end
         low_prev   = low_now;
         FIFO_EMPTY = (fifo_q.size() == 0);
      end
   end

   // Expects one frame of byte d; wait_start allows idle before it, otherwise it must follow at once.
   task automatic check_frame(input logic [7:0] d, input logic b8, input logic pe, input logic odd,
                              input bit wait_start, input bit last, input bit scramble, input string tag);
      bit   lv[$];
      int   nbits, ones, ticks, cyc;
      bit   ok, done_ok, busy_ok;
      logic exp_done;
      nbits = b8 ? 8 : 7;
      ones  = 0;
      lv.push_back(1'b0);
      for (int i = 0; i < nbits; i++) begin
         lv.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (pe) lv.push_back(((ones % 2) == 1) ^ odd);
      lv.push_back(1'b1);

      if (wait_start) begin
         cyc = 0;
         do begin
            @(negedge CLK);
            cyc++;
         end while (TX !== 1'b0 && cyc < LIMIT);
         checks++;
         if (TX !== 1'b0) begin
            errors++;
            $display("FAIL %s_start: TX=%b after %0d cycles, required start bit 0", tag, TX, cyc);
            return;
         end
      end else begin
         @(negedge CLK);
      end
      if (scramble) begin
         BIT8 = 1'($urandom); PARITY_EN = 1'($urandom); ODD_N_EVEN = 1'($urandom);
      end

      done_ok = 1'b1;
      busy_ok = 1'b1;
      foreach (lv[i]) begin
         ticks = 0; ok = 1'b1; cyc = 0;
         forever begin
            if (TX !== lv[i]) ok = 1'b0;
            if (TX_BUSY !== 1'b1) busy_ok = 1'b0;
            exp_done = (i == lv.size() - 1) && (BAUD_EN === 1'b1) && (ticks == OVERSAMPLE - 1);
            if (TX_DONE !== exp_done) done_ok = 1'b0;
            if (BAUD_EN === 1'b1) ticks++;
            if (ticks == OVERSAMPLE || cyc == LIMIT) break;
            @(negedge CLK);
            cyc++;
         end
         checks++;
         if (!ok || ticks != OVERSAMPLE) begin
            errors++;
            $display("FAIL %s_bit%0d: level_ok=%0d ticks=%0d, required TX=%b for %0d ticks",
                     tag, i, ok, ticks, lv[i], OVERSAMPLE);
         end
         if (i < lv.size() - 1) @(negedge CLK);
      end
      checks++;
      if (!done_ok) begin
         errors++;
         $display("FAIL %s_done: TX_DONE wrong in frame, required one pulse on the last stop tick", tag);
      end
      checks++;
      if (!busy_ok) begin
         errors++;
         $display("FAIL %s_busy: TX_BUSY low in frame, required 1", tag);
      end
      if (last) begin
         @(negedge CLK);
         checks++;
         if (TX !== 1'b1 || TX_BUSY !== 1'b0 || TX_DONE !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: TX=%b TX_BUSY=%b TX_DONE=%b, required 1/0/0", tag, TX, TX_BUSY, TX_DONE);
         end
      end
   endtask

   task automatic test_reset();
      int rd0;
      bit ok;
      RESET = 1'b0;
      baud_fast = 1'b1;
      rd0 = rd_count;
      fifo_q.push_back(8'h5A);
      ok = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         if (TX !== 1'b1 || FIFO_RDB !== 1'b1 || TX_BUSY !== 1'b0) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_hold: TX=%b RDB=%b BUSY=%b, required 1/1/0 while in reset", TX, FIFO_RDB, TX_BUSY);
      end
      RESET = 1'b1;
      @(negedge CLK);
      checks++;
      if (FIFO_RDB !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdb_pulse: RDB=%b one cycle after release, required 0", FIFO_RDB);
      end
      @(negedge CLK);
      checks++;
      if (FIFO_RDB !== 1'b1) begin
         errors++;
         $display("FAIL reset_rdb_single: RDB=%b second cycle, required 1", FIFO_RDB);
      end
      check_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "reset_frame");
      checks++;
      if (rd_count - rd0 != 1) begin
         errors++;
         $display("FAIL reset_reads: %0d strobes, required 1", rd_count - rd0);
      end
   endtask

   task automatic run_single(input logic [7:0] d, input logic b8, input logic pe, input logic odd,
                             input bit scramble, input string tag);
      int rd0;
      rd0 = rd_count;
      BIT8 = b8; PARITY_EN = pe; ODD_N_EVEN = odd;
      fifo_q.push_back(d);
      check_frame(d, b8, pe, odd, 1'b1, 1'b1, scramble, tag);
      checks++;
      if (rd_count - rd0 != 1) begin
         errors++;
         $display("FAIL %s_reads: %0d strobes, required 1", tag, rd_count - rd0);
      end
   endtask

   task automatic test_8n1();        run_single(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, "8n1");  endtask
   task automatic test_7e1();        run_single(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, "7e1");  endtask
   task automatic test_odd_parity(); run_single(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, "odd");  endtask

   task automatic test_config_hold();
      run_single(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, "cfg_hold");
   endtask

   task automatic run_burst(input logic [7:0] bytes[$], input logic b8, input logic pe,
                            input logic odd, input string tag);
      int rd0;
      rd0 = rd_count;
      BIT8 = b8; PARITY_EN = pe; ODD_N_EVEN = odd;
      foreach (bytes[i]) fifo_q.push_back(bytes[i]);
      foreach (bytes[i])
         check_frame(bytes[i], b8, pe, odd, i == 0, i == bytes.size() - 1, 1'b0, tag);
      checks++;
      if (rd_count - rd0 != bytes.size()) begin
         errors++;
         $display("FAIL %s_reads: %0d strobes, required %0d", tag, rd_count - rd0, bytes.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes[$];
      bytes = '{8'hA5, 8'h3C};
      run_burst(bytes, 1'b1, 1'b0, 1'b0, "b2b");
   endtask

   task automatic test_random();
      logic [7:0] bytes[$];
      baud_fast = 1'b0;
      for (int n = 0; n < 10; n++) begin
         bytes.delete();
         repeat ($urandom_range(1, 3)) bytes.push_back(8'($urandom));
         run_burst(bytes, 1'($urandom), 1'($urandom), 1'($urandom), "rand");
      end
      baud_fast = 1'b1;
   endtask

   task automatic test_mid_reset();
      int rd0, cyc;
      bit ok;
      BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
      fifo_q.push_back(8'h96);
      fifo_q.push_back(8'h5B);
      cyc = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (TX !== 1'b0 && cyc < LIMIT);
      checks++;
      if (TX !== 1'b0) begin
         errors++;
         $display("FAIL midrst_start: TX=%b, required start bit 0", TX);
      end
      repeat (70) @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      checks++;
      if (TX !== 1'b1 || TX_BUSY !== 1'b0 || FIFO_RDB !== 1'b1) begin
         errors++;
         $display("FAIL midrst_abort: TX=%b BUSY=%b RDB=%b, required 1/0/1", TX, TX_BUSY, FIFO_RDB);
      end
      rd0 = rd_count;
      ok  = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         if (FIFO_RDB !== 1'b1 || TX !== 1'b1) ok = 1'b0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midrst_quiet: strobe or TX low while reset held, required RDB=1 TX=1");
      end
      RESET = 1'b1;
      check_frame(8'h5B, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "midrst_fresh");
      checks++;
      if (rd_count - rd0 != 1) begin
         errors++;
         $display("FAIL midrst_reads: %0d strobes after reset, required 1", rd_count - rd0);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_7e1();
      test_odd_parity();
      test_back_to_back();
      test_config_hold();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
